// File: rtl/i2c_rx_packer.sv
// i2c_rx_packer: packs received I2C bytes into BYTES-wide words.
// The accumulator gathers bytes until the word is full, until a tlast byte
// arrives, or until a flush. The finished word then moves into a single
// output register. s_axis_tready only looks at the accumulator's done
// flag, so there is no combinational path from m_axis_tready to the input.
module i2c_rx_packer #(
   parameter int BYTES     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [7:0]                     s_axis_tdata,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic                           s_axis_tlast,
   input  logic                           flush,
   output logic [8*BYTES-1:0]             m_axis_tdata,
   output logic [BYTES-1:0]               m_axis_tkeep,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic [$clog2(BYTES+1)-1:0]     status_count
);

   localparam int CW = $clog2(BYTES+1);

   // accumulator
   logic [BYTES-1:0][7:0] acc_data_q, acc_data_d;
   logic [BYTES-1:0]      acc_keep_q, acc_keep_d;
   logic [CW-1:0]         acc_cnt_q,  acc_cnt_d;
   logic                  acc_last_q, acc_last_d;
   logic                  acc_done_q, acc_done_d;

   // output register
   logic [BYTES-1:0][7:0] out_data_q;
   logic [BYTES-1:0]      out_keep_q;
   logic                  out_last_q;
   logic                  out_valid_q;

   logic          in_hs;
   logic          out_load;
   logic [CW-1:0] lane;

   assign in_hs    = s_axis_tvalid & ~acc_done_q;
   // A finished word moves out whenever the output register is empty or
   // being drained in this same cycle.
   assign out_load = acc_done_q & (~out_valid_q | m_axis_tready);

   // Lane for the next byte: fill upward from lane 0, or downward from the top.
   always_comb begin
      lane = LSB_FIRST ? acc_cnt_q : (CW'(BYTES-1) - acc_cnt_q);
   end

   // Accumulator next state: unload takes priority; load and an input
   // handshake are mutually exclusive because both depend on done.
   always_comb begin
      acc_data_d = acc_data_q;
      acc_keep_d = acc_keep_q;
      acc_cnt_d  = acc_cnt_q;
      acc_last_d = acc_last_q;
      acc_done_d = acc_done_q;
      if (out_load) begin
         acc_data_d = '0;
         acc_keep_d = '0;
         acc_cnt_d  = '0;
         acc_last_d = 1'b0;
         acc_done_d = 1'b0;
      end else if (in_hs) begin
         for (int i = 0; i < BYTES; i++) begin
            if (lane == CW'(i)) begin
               acc_data_d[i] = s_axis_tdata;
               acc_keep_d[i] = 1'b1;
            end
         end
         acc_cnt_d  = acc_cnt_q + CW'(1);
         acc_last_d = s_axis_tlast;
         acc_done_d = (acc_cnt_q == CW'(BYTES-1)) | s_axis_tlast | flush;
      end else if (flush && (acc_cnt_q != '0) && !acc_done_q) begin
         // A flush on an empty accumulator would emit an empty word, so it is ignored.
         acc_done_d = 1'b1;
      end
   end

   // Accumulator state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_data_q <= '0;
         acc_keep_q <= '0;
         acc_cnt_q  <= '0;
         acc_last_q <= 1'b0;
         acc_done_q <= 1'b0;
      end else begin
         acc_data_q <= acc_data_d;
         acc_keep_q <= acc_keep_d;
         acc_cnt_q  <= acc_cnt_d;
         acc_last_q <= acc_last_d;
         acc_done_q <= acc_done_d;
      end
   end

   // Output register: load a finished word, or drop valid once it is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (out_load) begin
         out_data_q  <= acc_data_q;
         out_keep_q  <= acc_keep_q;
         out_last_q  <= acc_last_q;
         out_valid_q <= 1'b1;
      end else if (out_valid_q && m_axis_tready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign s_axis_tready = ~acc_done_q;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tkeep  = out_keep_q;
   assign m_axis_tlast  = out_last_q;
   assign m_axis_tvalid = out_valid_q;
   assign status_count  = acc_cnt_q;

endmodule

// File: tb/tb_i2c_rx_packer.sv
// tb_i2c_rx_packer: drives one byte stream into two packers, one filling
// lanes upward and one filling them downward. Expected words are queued
// when stimulus is driven and compared as each word leaves.
module tb_i2c_rx_packer;

   logic        clk, rst_n;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tlast, flush, m_ready;

   logic        a_sready, a_mvalid, a_mlast;
   logic [31:0] a_mdata;
   logic [3:0]  a_mkeep;
   logic [2:0]  a_status;
   logic        b_sready, b_mvalid, b_mlast;
   logic [31:0] b_mdata;
   logic [3:0]  b_mkeep;
   logic [2:0]  b_status;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   i2c_rx_packer #(.BYTES(4), .LSB_FIRST(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(a_sready),
      .s_axis_tlast(s_tlast), .flush(flush),
      .m_axis_tdata(a_mdata), .m_axis_tkeep(a_mkeep), .m_axis_tvalid(a_mvalid),
      .m_axis_tready(m_ready), .m_axis_tlast(a_mlast), .status_count(a_status));

   i2c_rx_packer #(.BYTES(4), .LSB_FIRST(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(b_sready),
      .s_axis_tlast(s_tlast), .flush(flush),
      .m_axis_tdata(b_mdata), .m_axis_tkeep(b_mkeep), .m_axis_tvalid(b_mvalid),
      .m_axis_tready(m_ready), .m_axis_tlast(b_mlast), .status_count(b_status));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Queue one expected word for the upward packer and its lane-mirrored twin.
   task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
      exp_t ea, eb;
      ea.d = d; ea.k = k; ea.l = l;
      eb.l = l;
      for (int i = 0; i < 4; i++) begin
         eb.d[8*(3-i) +: 8] = d[8*i +: 8];
         eb.k[3-i]          = k[i];
      end
      qa.push_back(ea);
      qb.push_back(eb);
   endtask

   // Offer one byte; the handshake happens on the posedge after a negedge with tready high.
   task automatic send(input logic [7:0] b, input logic l, input logic f);
      int n;
      s_tdata = b; s_tvalid = 1'b1; s_tlast = l; flush = f;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!a_sready && n < 200);
      if (!a_sready) chk("tready_timeout", {63'b0, a_sready}, 64'd1);
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0; flush = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_a_sready"}, {63'b0, a_sready}, 64'd1);
      chk({tag, "_a_mvalid"}, {63'b0, a_mvalid}, 64'd0);
      chk({tag, "_a_mdata"},  {32'b0, a_mdata},  64'd0);
      chk({tag, "_a_mkeep"},  {60'b0, a_mkeep},  64'd0);
      chk({tag, "_a_mlast"},  {63'b0, a_mlast},  64'd0);
      chk({tag, "_a_status"}, {61'b0, a_status}, 64'd0);
      chk({tag, "_b_mvalid"}, {63'b0, b_mvalid}, 64'd0);
      chk({tag, "_b_status"}, {61'b0, b_status}, 64'd0);
   endtask

   // Scoreboard for the upward packer.
   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rst_n && a_mvalid && m_ready) begin
         if (qa.size() == 0) chk("a_spurious_word", {63'b0, a_mvalid}, 64'd0);
         else begin
            e = qa.pop_front();
            chk("a_tdata", {32'b0, a_mdata}, {32'b0, e.d});
            chk("a_tkeep", {60'b0, a_mkeep}, {60'b0, e.k});
            chk("a_tlast", {63'b0, a_mlast}, {63'b0, e.l});
         end
      end
   end

   // Scoreboard for the downward packer.
   always @(negedge clk) begin : mon_b
      exp_t e;
      if (rst_n && b_mvalid && m_ready) begin
         if (qb.size() == 0) chk("b_spurious_word", {63'b0, b_mvalid}, 64'd0);
         else begin
            e = qb.pop_front();
            chk("b_tdata", {32'b0, b_mdata}, {32'b0, e.d});
            chk("b_tkeep", {60'b0, b_mkeep}, {60'b0, e.k});
            chk("b_tlast", {63'b0, b_mlast}, {63'b0, e.l});
         end
      end
   end

   initial begin
      int lowcnt;
      rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; flush = 1'b0; m_ready = 1'b1;
      #2;
      check_reset("rst_init");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);

      // full word, one ready-low bubble, one-cycle latency
      push(32'h44332211, 4'hF, 1'b0);
      lowcnt = 0;
      fork
         begin
            repeat (10) begin
               @(negedge clk);
               if (!a_sready) lowcnt++;
            end
         end
         begin
            send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0); send(8'h44, 0, 0);
            @(negedge clk);
            chk("lat_valid_n", {63'b0, a_mvalid}, 64'd0);
            @(negedge clk);
            chk("lat_valid_n1", {63'b0, a_mvalid}, 64'd1);
         end
      join
      chk("bubble_cycles", 64'(lowcnt), 64'd1);
      idle(3);

      // tlast closes a two-byte word
      push(32'h0000BBAA, 4'h3, 1'b1);
      send(8'hAA, 0, 0);
      chk("cnt_after_one", {61'b0, a_status}, 64'd1);
      send(8'hBB, 1, 0);
      @(negedge clk); @(negedge clk);
      chk("cnt_after_last", {61'b0, a_status}, 64'd0);
      idle(3);

      // flush emits a partial word; a flush on an empty accumulator does nothing
      push(32'h0000005A, 4'h1, 1'b0);
      send(8'h5A, 0, 0);
      idle(3);
      pulse_flush();
      idle(4);
      pulse_flush();
      idle(4);
      chk("empty_flush_cnt", {61'b0, a_status}, 64'd0);
      chk("empty_flush_q", 64'(qa.size()), 64'd0);

      // explicit downward-lane case
      qa.push_back('{d: 32'h00002211, k: 4'h3, l: 1'b1});
      qb.push_back('{d: 32'h11220000, k: 4'hC, l: 1'b1});
      send(8'h11, 0, 0);
      send(8'h22, 1, 0);
      idle(4);

      // output stalled: one word held out, one in the accumulator, input blocked
      m_ready = 1'b0;
      push(32'h04030201, 4'hF, 1'b0);
      push(32'h08070605, 4'hF, 1'b0);
      push(32'h0C0B0A09, 4'hF, 1'b0);
      fork
         begin
            for (int i = 1; i <= 12; i++) send(8'(i), 0, 0);
         end
         begin
            repeat (20) @(negedge clk);
            chk("stall_a_valid", {63'b0, a_mvalid}, 64'd1);
            chk("stall_a_sready", {63'b0, a_sready}, 64'd0);
            chk("stall_a_cnt", {61'b0, a_status}, 64'd4);
            chk("stall_b_data", {32'b0, b_mdata}, 64'h01020304);
            repeat (4) begin
               @(negedge clk);
               chk("stall_a_data", {32'b0, a_mdata}, 64'h04030201);
            end
            @(posedge clk); #1;
            m_ready = 1'b1;
         end
      join
      idle(6);
      chk("stall_drained", 64'(qa.size()), 64'd0);

      // reset mid-word discards the partial word
      send(8'hE1, 0, 0);
      send(8'hE2, 0, 0);
      rst_n = 1'b0;
      #2;
      check_reset("rst_mid");
      idle(3);
      rst_n = 1'b1;
      idle(1);
      push(32'hA4A3A2A1, 4'hF, 1'b0);
      send(8'hA1, 0, 0); send(8'hA2, 0, 0); send(8'hA3, 0, 0); send(8'hA4, 0, 0);
      idle(8);

      chk("a_queue_empty", 64'(qa.size()), 64'd0);
      chk("b_queue_empty", 64'(qb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
